// File: rtl/lite_16_prog_loader_pkg.sv
// Shared definitions for the LITE-16 program loader: FSM state encodings,
// error codes and checksum helper.
package lite_16_defs;

    typedef enum logic [2:0] {
        CNT_HI  = 3'd0,
        CNT_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CHK     = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } load_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;

    // Running mod-256 byte sum; an image is good when the total over all bytes is zero.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/lite_16_prog_loader.sv
// Writer side of LITE-16 program memory: assembles a byte stream into 16-bit words,
// writes them from word 0 and holds the CPU in reset until a checksummed image is in.
module lite_16_prog_loader
    import lite_16_defs::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // 17 bits so that a full 64K-word memory still has a representable capacity.
    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    load_state_e       state_r;
    load_state_e       state_s;
    logic [7:0]        hi_r;
    logic [15:0]       words_left_r;
    logic [ADDR_W-1:0] wr_idx_r;
    logic [7:0]        csum_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       mem_wdata_r;
    logic              done_r;
    logic              err_r;
    logic [1:0]        err_code_r;
    logic              cpu_hold_r;

    logic              in_ready_s;
    logic              xfer_s;
    logic              restart_s;
    logic [15:0]       count_s;
    logic              over_s;
    logic [7:0]        csum_next_s;

    assign in_ready_s  = (state_r != DONE) && (state_r != ERR);
    assign xfer_s      = in_valid && in_ready_s;
    assign restart_s   = reload && !in_ready_s;
    assign count_s     = {hi_r, in_data};
    assign over_s      = {1'b0, count_s} > CAP;
    assign csum_next_s = csum_add(csum_r, in_data);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= CNT_HI;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; every receive state advances only on an accepted byte.
    always_comb begin
        state_s = state_r;
        case (state_r)
            CNT_HI: begin
                if (xfer_s) state_s = CNT_LO;
                else        state_s = state_r;
            end
            CNT_LO: begin
                if (!xfer_s)                  state_s = state_r;
                else if (over_s)              state_s = ERR;
                else if (count_s == 16'd0)    state_s = CHK;
                else                          state_s = DATA_HI;
            end
            DATA_HI: begin
                if (xfer_s) state_s = DATA_LO;
                else        state_s = state_r;
            end
            DATA_LO: begin
                if (!xfer_s)                    state_s = state_r;
                else if (words_left_r == 16'd1) state_s = CHK;
                else                            state_s = DATA_HI;
            end
            CHK: begin
                if (!xfer_s)                   state_s = state_r;
                else if (csum_next_s == 8'h00) state_s = DONE;
                else                           state_s = ERR;
            end
            DONE, ERR: begin
                if (reload) state_s = CNT_HI;
                else        state_s = state_r;
            end
            default: state_s = CNT_HI;
        endcase
    end

    // Datapath: byte capture, checksum, word write strobe and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r         <= 8'h00;
            words_left_r <= 16'd0;
            wr_idx_r     <= '0;
            csum_r       <= 8'h00;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 16'h0000;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= ERR_NONE;
            cpu_hold_r   <= 1'b1;
        end else begin
            mem_we_r <= 1'b0;
            if (restart_s) begin
                words_left_r <= 16'd0;
                wr_idx_r     <= '0;
                csum_r       <= 8'h00;
                mem_addr_r   <= '0;
                done_r       <= 1'b0;
                err_r        <= 1'b0;
                err_code_r   <= ERR_NONE;
                cpu_hold_r   <= 1'b1;
            end else if (xfer_s) begin
                csum_r <= csum_next_s;
                case (state_r)
                    CNT_HI, DATA_HI: begin
                        hi_r <= in_data;
                    end
                    CNT_LO: begin
                        words_left_r <= count_s;
                        if (over_s) begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_COUNT;
                        end else begin
                            err_r      <= 1'b0;
                        end
                    end
                    DATA_LO: begin
                        // Word count bounds writes, so wr_idx_r never wraps into an extra write.
                        mem_we_r     <= 1'b1;
                        mem_wdata_r  <= {hi_r, in_data};
                        mem_addr_r   <= wr_idx_r;
                        wr_idx_r     <= wr_idx_r + ADDR_W'(1);
                        words_left_r <= words_left_r - 16'd1;
                    end
                    CHK: begin
                        if (csum_next_s == 8'h00) begin
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_CSUM;
                        end
                    end
                    default: begin
                        hi_r <= hi_r;
                    end
                endcase
            end else begin
                csum_r <= csum_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_lite_16_prog_loader.sv
// Directed bench for lite_16_prog_loader: a default-size instance for the main
// image tests and an ADDR_W=2 instance for the capacity boundary.
module tb_lite_16_prog_loader;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] word_q_t[$];

    logic        clk;
    logic        rst;

    logic        v8, rl8, rdy8, we8, hold8, done8, err8;
    logic [7:0]  d8, addr8;
    logic [15:0] wd8;
    logic [1:0]  ec8;

    logic        vs, rls, rdys, wes, holds, dones, errs;
    logic [7:0]  ds;
    logic [1:0]  addrs;
    logic [15:0] wds;
    logic [1:0]  ecs;

    int total;
    int bad;

    logic [7:0]  la8[$];
    logic [15:0] ld8[$];
    logic [1:0]  las[$];
    logic [15:0] lds[$];

    lite_16_prog_loader #(.ADDR_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
        .reload(rl8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
        .cpu_hold(hold8), .done(done8), .err(err8), .err_code(ec8)
    );

    lite_16_prog_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(vs), .in_data(ds), .in_ready(rdys),
        .reload(rls), .mem_we(wes), .mem_addr(addrs), .mem_wdata(wds),
        .cpu_hold(holds), .done(dones), .err(errs), .err_code(ecs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write logger: every strobed cycle becomes one entry, so a stretched pulse shows up as an extra write.
    always @(negedge clk) begin
        if (we8 === 1'b1) begin
            la8.push_back(addr8);
            ld8.push_back(wd8);
        end
        if (wes === 1'b1) begin
            las.push_back(addrs);
            lds.push_back(wds);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Presents one byte at a negedge, waits (bounded) for in_ready, then checks the write strobe
    // on the negedge right after the accepting posedge.
    task automatic send(input bit sm, input logic [7:0] b, input bit exp_we);
        int n;
        n = 0;
        if (sm) begin vs = 1'b1; ds = b; end
        else    begin v8 = 1'b1; d8 = b; end
        while (((sm ? rdys : rdy8) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_stall", 32'd0, 32'd1);
        @(negedge clk);
        vs = 1'b0;
        v8 = 1'b0;
        check(sm ? "we_small" : "we_main", 32'(sm ? wes : we8), 32'(exp_we));
    endtask

    task automatic send_image(input bit sm, input byte_q_t img, input int maxgap, input int rl_at);
        int n;
        int cap;
        bit dl;
        n   = (img.size() >= 2) ? int'({img[0], img[1]}) : 0;
        cap = sm ? 4 : 256;
        for (int i = 0; i < img.size(); i++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
            if (i == rl_at) begin
                rl8 = 1'b1;
                @(negedge clk);
                rl8 = 1'b0;
            end
            dl = (i >= 3) && (i < 2 + 2 * n) && (((i - 2) % 2) == 1) && (n <= cap);
            send(sm, img[i], dl);
        end
    endtask

    task automatic check_writes(input bit sm, input int start, input word_q_t exp);
        int cnt;
        cnt = sm ? (las.size() - start) : (la8.size() - start);
        check("write_count", 32'(cnt), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < cnt; k++) begin
            check("write_addr", 32'(sm ? 8'(las[start + k]) : la8[start + k]), 32'(k));
            check("write_data", 32'(sm ? lds[start + k] : ld8[start + k]), 32'(exp[k]));
        end
    endtask

    task automatic do_reload(input bit sm);
        if (sm) rls = 1'b1; else rl8 = 1'b1;
        @(negedge clk);
        rls = 1'b0;
        rl8 = 1'b0;
        check("rl_hold",  32'(sm ? holds : hold8), 32'd1);
        check("rl_done",  32'(sm ? dones : done8), 32'd0);
        check("rl_err",   32'(sm ? errs  : err8),  32'd0);
        check("rl_code",  32'(sm ? ecs   : ec8),   32'd0);
        check("rl_addr",  32'(sm ? 8'(addrs) : addr8), 32'd0);
        check("rl_ready", 32'(sm ? rdys  : rdy8),  32'd1);
    endtask

    byte_q_t img_good, img_bad, img_zero, img_over, img_full;
    word_q_t w_good, w_full, w_none;
    int start;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        v8 = 1'b0; rl8 = 1'b0; d8 = 8'h00;
        vs = 1'b0; rls = 1'b0; ds = 8'h00;
        // 02+12+34+AB+CD = 0x1C0, so 0x40 brings the byte sum to zero.
        img_good = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        img_bad  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h33};
        img_zero = '{8'h00, 8'h00, 8'h00};
        img_over = '{8'h00, 8'h05};
        // 04 + 01+02+03+04 = 0x0E, checksum 0xF2.
        img_full = '{8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'hF2};
        w_good = '{16'h1234, 16'hABCD};
        w_full = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        w_none = '{};

        repeat (3) @(negedge clk);
        check("rst_hold", 32'(hold8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("init_ready", 32'(rdy8), 32'd1);
        check("init_hold",  32'(hold8), 32'd1);
        check("init_done",  32'(done8), 32'd0);
        check("init_addr",  32'(addr8), 32'd0);

        // Reset mid-load after the first word went out.
        send(1'b0, 8'h00, 1'b0);
        send(1'b0, 8'h02, 1'b0);
        send(1'b0, 8'h12, 1'b0);
        send(1'b0, 8'h34, 1'b1);
        send(1'b0, 8'hAB, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_we",    32'(we8),   32'd0);
        check("mid_rst_addr",  32'(addr8), 32'd0);
        check("mid_rst_wdata", 32'(wd8),   32'd0);
        check("mid_rst_hold",  32'(hold8), 32'd1);
        check("mid_rst_done",  32'(done8), 32'd0);
        check("mid_rst_err",   32'(err8),  32'd0);
        check("mid_rst_code",  32'(ec8),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(rdy8), 32'd1);

        // Good image, back-to-back bytes.
        start = la8.size();
        send_image(1'b0, img_good, 0, -1);
        check("good_done",  32'(done8), 32'd1);
        check("good_hold",  32'(hold8), 32'd0);
        check("good_ready", 32'(rdy8),  32'd0);
        check("good_err",   32'(err8),  32'd0);
        check("good_addr",  32'(addr8), 32'd1);
        check_writes(1'b0, start, w_good);

        // Bytes offered in DONE must be ignored.
        start = la8.size();
        v8 = 1'b1; d8 = 8'hFF;
        repeat (3) @(negedge clk);
        v8 = 1'b0;
        check("done_sticky", 32'(done8), 32'd1);
        check("done_ready",  32'(rdy8),  32'd0);
        check_writes(1'b0, start, w_none);
        do_reload(1'b0);

        // Bad checksum.
        start = la8.size();
        send_image(1'b0, img_bad, 0, -1);
        check("bad_err",  32'(err8),  32'd1);
        check("bad_code", 32'(ec8),   32'd2);
        check("bad_hold", 32'(hold8), 32'd1);
        check("bad_done", 32'(done8), 32'd0);
        check_writes(1'b0, start, w_good);
        do_reload(1'b0);

        // Random gaps, plus a reload pulse mid-receive that must be ignored.
        start = la8.size();
        send_image(1'b0, img_good, 3, 3);
        check("gap_done", 32'(done8), 32'd1);
        check("gap_hold", 32'(hold8), 32'd0);
        check_writes(1'b0, start, w_good);
        do_reload(1'b0);

        // Zero-word image, then reload and a real image.
        start = la8.size();
        send_image(1'b0, img_zero, 0, -1);
        check("zero_done", 32'(done8), 32'd1);
        check_writes(1'b0, start, w_none);
        do_reload(1'b0);
        start = la8.size();
        send_image(1'b0, img_good, 0, -1);
        check("again_done", 32'(done8), 32'd1);
        check_writes(1'b0, start, w_good);

        // Capacity boundary on a 4-word memory.
        send_image(1'b1, img_over, 0, -1);
        check("over_err",   32'(errs),  32'd1);
        check("over_code",  32'(ecs),   32'd1);
        check("over_ready", 32'(rdys),  32'd0);
        check("over_hold",  32'(holds), 32'd1);
        check_writes(1'b1, 0, w_none);
        do_reload(1'b1);
        send_image(1'b1, img_full, 0, -1);
        check("full_done", 32'(dones), 32'd1);
        check("full_addr", 32'(addrs), 32'd3);
        check("full_hold", 32'(holds), 32'd0);
        check_writes(1'b1, 0, w_full);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
